// File: rtl/video_pkg.sv
// Shared definitions for the pixel-correction pipeline.
// Holds the default frame geometry, the colour depth and coordinate width
// shared with the correction stages, and the coordinate-generator state
// encoding.
package video_pkg;

  localparam int IMG_WIDTH_DEF  = 1280;
  localparam int IMG_HEIGHT_DEF = 720;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_W_DEF      = 11;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    FRAME     = 1'b1
  } coord_state_t;

endpackage

// File: rtl/video_coord_gen_if.sv
// Pixel stream bundle around the coordinate generator.
//   Source side  : vs_i, de_i, r_i/g_i/b_i (raw timing + pixel)
//   Tagged side  : valid_o, vsync_o (EOF pulse), r_o/g_o/b_o,
//                  h_cnt_o/v_cnt_o (pixel coordinates)
// Modports:
//   master : the generator (consumes source, produces tagged stream)
//   slave  : the environment around it (drives source, observes tags)
interface video_coord_gen_if
  import video_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) ();

  logic                  vs_i;
  logic                  de_i;
  logic [DATA_WIDTH-1:0] r_i;
  logic [DATA_WIDTH-1:0] g_i;
  logic [DATA_WIDTH-1:0] b_i;

  logic                  valid_o;
  logic                  vsync_o;
  logic [DATA_WIDTH-1:0] r_o;
  logic [DATA_WIDTH-1:0] g_o;
  logic [DATA_WIDTH-1:0] b_o;
  logic [CNT_W-1:0]      h_cnt_o;
  logic [CNT_W-1:0]      v_cnt_o;

  modport master (
    input  vs_i, de_i, r_i, g_i, b_i,
    output valid_o, vsync_o, r_o, g_o, b_o, h_cnt_o, v_cnt_o
  );

  modport slave (
    output vs_i, de_i, r_i, g_i, b_i,
    input  valid_o, vsync_o, r_o, g_o, b_o, h_cnt_o, v_cnt_o
  );

endinterface

// File: rtl/video_sync_edge.sv
// Timing-edge detector for raw video sync.
// Registers the normalised vsync level and the effective data enable and
// derives the frame-start edge and the line-end (falling de) strobe.
// Ports:
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   vs_act     : vsync at its active level (polarity already applied)
//   de_eff     : data enable with vsync blanking already applied
//   vs_edge    : vsync just became active this cycle
//   line_end   : effective de just fell this cycle
module video_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic vs_act,
  input  logic de_eff,
  output logic vs_edge,
  output logic line_end
);

  logic vs_act_d;
  logic de_eff_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_act_d <= 1'b0;
      de_eff_d <= 1'b0;
    end else begin
      vs_act_d <= vs_act;
      de_eff_d <= de_eff;
    end
  end

  assign vs_edge  = vs_act & ~vs_act_d;
  assign line_end = de_eff_d & ~de_eff;

endmodule

// File: rtl/video_coord_gen.sv
// Coordinate generator: first stage of the pixel-correction pipeline.
// Locks to the first vsync edge, then tags every in-range pixel with its
// column/row, suppresses pixels beyond the active window, emits a one-cycle
// EOF pulse per completed frame and keeps sticky line/frame error flags.
// All outputs are registered; a pixel at input cycle T appears at T+1.
// Ports:
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   vid          : source stream in, tagged stream out (master modport)
//   clr_err_i    : one-cycle pulse clearing the sticky error flags
//   line_err_o   : sticky, some line width differed from IMG_WIDTH
//   frame_err_o  : sticky, some frame had a bad line or wrong line count
//   frame_cnt_o  : completed-frame counter, wraps 65535 -> 0
module video_coord_gen
  import video_pkg::*;
#(
  parameter int   IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int   IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int   DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int   CNT_W      = CNT_W_DEF,
  parameter logic VS_POL     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  video_coord_gen_if.master    vid,
  input  logic                 clr_err_i,
  output logic                 line_err_o,
  output logic                 frame_err_o,
  output logic [15:0]          frame_cnt_o
);

  localparam logic [CNT_W-1:0] W_C  = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] H_C  = CNT_W'(IMG_HEIGHT);
  localparam logic [CNT_W-1:0] H1_C = CNT_W'(IMG_HEIGHT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic [CNT_W-1:0] lim);
    sat_inc = (val >= lim) ? lim : val + CNT_W'(1);
  endfunction

  logic vs_act;
  logic de_eff;
  logic vs_edge;
  logic line_end;

  assign vs_act = (vid.vs_i == VS_POL);
  assign de_eff = vid.de_i & ~vs_act;

  video_sync_edge u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .vs_act   (vs_act),
    .de_eff   (de_eff),
    .vs_edge  (vs_edge),
    .line_end (line_end)
  );

  coord_state_t          state, state_nx;
  logic [CNT_W-1:0]      hcnt, hcnt_nx;
  logic [CNT_W-1:0]      vcnt, vcnt_nx;
  // line_ovf remembers that the line ran past IMG_WIDTH, since hcnt
  // saturates and could otherwise look like an exact-width line.
  logic                  line_ovf, line_ovf_nx;
  logic                  frame_bad, frame_bad_nx;

  logic                  valid_nx;
  logic                  vsync_nx;
  logic [DATA_WIDTH-1:0] r_nx, g_nx, b_nx;
  logic [CNT_W-1:0]      h_out_nx, v_out_nx;
  logic                  line_set, frame_set;
  logic                  line_err_nx, frame_err_nx;
  logic [15:0]           frame_cnt_nx;

  always_comb begin
    state_nx     = state;
    hcnt_nx      = hcnt;
    vcnt_nx      = vcnt;
    line_ovf_nx  = line_ovf;
    frame_bad_nx = frame_bad;
    valid_nx     = 1'b0;
    vsync_nx     = 1'b0;
    r_nx         = vid.r_o;
    g_nx         = vid.g_o;
    b_nx         = vid.b_o;
    h_out_nx     = vid.h_cnt_o;
    v_out_nx     = vid.v_cnt_o;
    line_set     = 1'b0;
    frame_set    = 1'b0;
    frame_cnt_nx = frame_cnt_o;

    case (state)
      SYNC_WAIT: begin
        // No complete frame exists yet, so the first edge only locks.
        hcnt_nx      = '0;
        vcnt_nx      = '0;
        line_ovf_nx  = 1'b0;
        frame_bad_nx = 1'b0;
        if (vs_edge) begin
          state_nx = FRAME;
        end
      end

      FRAME: begin
        if (de_eff) begin
          if ((hcnt < W_C) && (vcnt < H_C)) begin
            valid_nx = 1'b1;
            r_nx     = vid.r_i;
            g_nx     = vid.g_i;
            b_nx     = vid.b_i;
            h_out_nx = hcnt;
            v_out_nx = vcnt;
          end else begin
            line_set = 1'b1;
          end
          if (hcnt >= W_C) begin
            line_ovf_nx = 1'b1;
          end
          hcnt_nx = sat_inc(hcnt, W_C);
        end

        // line_end is resolved before vs_edge so the EOF check sees the
        // line that closes in the same cycle.
        if (line_end) begin
          if ((hcnt != W_C) || line_ovf) begin
            line_set     = 1'b1;
            frame_bad_nx = 1'b1;
          end
          vcnt_nx     = sat_inc(vcnt, H1_C);
          hcnt_nx     = '0;
          line_ovf_nx = 1'b0;
        end

        if (vs_edge) begin
          vsync_nx     = 1'b1;
          frame_cnt_nx = frame_cnt_o + 16'd1;
          if ((vcnt_nx != H_C) || frame_bad_nx) begin
            frame_set = 1'b1;
          end
          vcnt_nx      = '0;
          hcnt_nx      = '0;
          line_ovf_nx  = 1'b0;
          frame_bad_nx = 1'b0;
        end
      end
    endcase

    // Set wins over a simultaneous clear.
    line_err_nx  = line_set  | (line_err_o  & ~clr_err_i);
    frame_err_nx = frame_set | (frame_err_o & ~clr_err_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SYNC_WAIT;
      hcnt        <= '0;
      vcnt        <= '0;
      line_ovf    <= 1'b0;
      frame_bad   <= 1'b0;
      vid.valid_o <= 1'b0;
      vid.vsync_o <= 1'b0;
      vid.r_o     <= '0;
      vid.g_o     <= '0;
      vid.b_o     <= '0;
      vid.h_cnt_o <= '0;
      vid.v_cnt_o <= '0;
      line_err_o  <= 1'b0;
      frame_err_o <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      state       <= state_nx;
      hcnt        <= hcnt_nx;
      vcnt        <= vcnt_nx;
      line_ovf    <= line_ovf_nx;
      frame_bad   <= frame_bad_nx;
      vid.valid_o <= valid_nx;
      vid.vsync_o <= vsync_nx;
      vid.r_o     <= r_nx;
      vid.g_o     <= g_nx;
      vid.b_o     <= b_nx;
      vid.h_cnt_o <= h_out_nx;
      vid.v_cnt_o <= v_out_nx;
      line_err_o  <= line_err_nx;
      frame_err_o <= frame_err_nx;
      frame_cnt_o <= frame_cnt_nx;
    end
  end

endmodule

// File: tb/tb_video_coord_gen.sv
// Bench for video_coord_gen on a reduced 16x8 frame.
module tb_video_coord_gen;

  localparam int W = 16;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_err = 1'b0;
  logic line_err;
  logic frame_err;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  video_coord_gen_if #(.DATA_WIDTH(8), .CNT_W(11)) vif ();

  video_coord_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_WIDTH(8),
    .CNT_W     (11),
    .VS_POL    (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vid        (vif),
    .clr_err_i  (clr_err),
    .line_err_o (line_err),
    .frame_err_o(frame_err),
    .frame_cnt_o(frame_cnt)
  );

  // Reference model state (unbounded pixel/line counts per the frame rules).
  bit m_locked = 0;
  int m_col = 0;
  int m_row = 0;
  bit m_fbad = 0;
  bit m_vs_prev = 0;
  bit m_de_prev = 0;

  // Model result for the pending edge, and the expectation currently visible.
  logic n_valid = 0, n_vsync = 0, n_lerr = 0, n_ferr = 0;
  int   n_h = 0, n_v = 0, n_fcnt = 0;
  logic [7:0] n_r = 0, n_g = 0, n_b = 0;
  logic e_valid = 0, e_vsync = 0, e_lerr = 0, e_ferr = 0;
  int   e_h = 0, e_v = 0, e_fcnt = 0;
  logic [7:0] e_r = 0, e_g = 0, e_b = 0;

  // Literal expectations handed to the compare process.
  string pin_name [128];
  int    pin_act  [128];
  int    pin_exp  [128];
  int    pin_wr = 0;
  bit    done = 0;
  int    cyc = 0;

  int tests = 0;
  int fails = 0;
  int n_valid_seen = 0;
  int n_vsync_seen = 0;

  task automatic pin(input string nm, input int act, input int exp);
    pin_name[pin_wr] = nm;
    pin_act[pin_wr]  = act;
    pin_exp[pin_wr]  = exp;
    pin_wr++;
  endtask

  task automatic model_clear();
    m_locked = 0; m_col = 0; m_row = 0; m_fbad = 0;
    m_vs_prev = 0; m_de_prev = 0;
    n_valid = 0; n_vsync = 0; n_lerr = 0; n_ferr = 0;
    n_h = 0; n_v = 0; n_fcnt = 0; n_r = 0; n_g = 0; n_b = 0;
  endtask

  task automatic apply_exp();
    e_valid = n_valid; e_vsync = n_vsync; e_lerr = n_lerr; e_ferr = n_ferr;
    e_h = n_h; e_v = n_v; e_fcnt = n_fcnt; e_r = n_r; e_g = n_g; e_b = n_b;
  endtask

  task automatic model_step(input logic vs, input logic de, input logic [7:0] r,
                            input logic [7:0] g, input logic [7:0] b, input logic clr);
    bit vs_act, de_eff, vs_edge, line_end, lset, fset;
    vs_act   = (vs == 1'b1);
    de_eff   = de && !vs_act;
    vs_edge  = vs_act && !m_vs_prev;
    line_end = m_de_prev && !de_eff;
    lset = 0; fset = 0; n_valid = 0; n_vsync = 0;
    if (!m_locked) begin
      if (vs_edge) m_locked = 1;
    end else begin
      if (de_eff) begin
        if (m_col < W && m_row < H) begin
          n_valid = 1; n_h = m_col; n_v = m_row; n_r = r; n_g = g; n_b = b;
        end else begin
          lset = 1;
        end
        m_col++;
      end
      if (line_end) begin
        if (m_col != W) begin lset = 1; m_fbad = 1; end
        m_row++;
        m_col = 0;
      end
      if (vs_edge) begin
        n_vsync = 1;
        n_fcnt = (n_fcnt + 1) % 65536;
        if (m_row != H || m_fbad) fset = 1;
        m_row = 0; m_col = 0; m_fbad = 0;
      end
    end
    n_lerr = lset || (n_lerr && !clr);
    n_ferr = fset || (n_ferr && !clr);
    m_vs_prev = vs_act;
    m_de_prev = de_eff;
  endtask

  task automatic step(input logic vs, input logic de, input logic clr = 1'b0);
    cyc++;
    vif.vs_i = vs;
    vif.de_i = de;
    vif.r_i  = 8'(cyc);
    vif.g_i  = 8'(cyc * 7);
    vif.b_i  = 8'(255 - cyc);
    clr_err  = clr;
    model_step(vs, de, vif.r_i, vif.g_i, vif.b_i, clr);
    @(posedge clk);
    #1;
    apply_exp();
  endtask

  task automatic do_line(input int n);
    repeat (n) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
  endtask

  task automatic lock_pulse();
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic eof(input string tag, input int fcnt, input int ferr);
    step(1'b1, 1'b0);
    pin({tag, "_vsync"}, int'(vif.vsync_o), 1);
    pin({tag, "_frame_cnt"}, int'(frame_cnt), fcnt);
    pin({tag, "_frame_err"}, int'(frame_err), ferr);
    step(1'b1, 1'b0);
    pin({tag, "_vsync_end"}, int'(vif.vsync_o), 0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
  endtask

  // Compare process: DUT against the model every cycle, then literal pins.
  initial begin
    int pin_rd;
    pin_rd = 0;
    forever begin
      @(negedge clk);
      tests++;
      if ({vif.valid_o, vif.vsync_o, line_err, frame_err} !== {e_valid, e_vsync, e_lerr, e_ferr} ||
          int'(vif.h_cnt_o) != e_h || int'(vif.v_cnt_o) != e_v || int'(frame_cnt) != e_fcnt ||
          {vif.r_o, vif.g_o, vif.b_o} !== {e_r, e_g, e_b}) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got valid=%0b vsync=%0b h=%0d v=%0d rgb=%h%h%h lerr=%0b ferr=%0b fcnt=%0d required valid=%0b vsync=%0b h=%0d v=%0d rgb=%h%h%h lerr=%0b ferr=%0b fcnt=%0d",
                 $time, vif.valid_o, vif.vsync_o, vif.h_cnt_o, vif.v_cnt_o, vif.r_o, vif.g_o, vif.b_o,
                 line_err, frame_err, frame_cnt, e_valid, e_vsync, e_h, e_v, e_r, e_g, e_b,
                 e_lerr, e_ferr, e_fcnt);
      end
      if (vif.valid_o) n_valid_seen++;
      if (vif.vsync_o) n_vsync_seen++;
      while (pin_rd < pin_wr) begin
        tests++;
        if (pin_act[pin_rd] != pin_exp[pin_rd]) begin
          fails++;
          $display("FAIL %s got %0d required %0d", pin_name[pin_rd], pin_act[pin_rd], pin_exp[pin_rd]);
        end
        pin_rd++;
      end
      if (done) begin
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench did not complete");
  end

  initial begin
    int v0, s0;
    vif.vs_i = 1'b0; vif.de_i = 1'b0;
    vif.r_i = '0; vif.g_i = '0; vif.b_i = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    pin("rst_valid", int'(vif.valid_o), 0);
    pin("rst_vsync", int'(vif.vsync_o), 0);
    pin("rst_fcnt", int'(frame_cnt), 0);
    pin("rst_lerr", int'(line_err), 0);
    rst_n = 1'b1;

    // Pixels before any lock, then the locking edge
    v0 = n_valid_seen;
    repeat (50) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    pin("prelock_valid_cnt", n_valid_seen - v0, 0);
    s0 = n_vsync_seen;
    lock_pulse();
    pin("lock_no_vsync", n_vsync_seen - s0, 0);
    pin("lock_fcnt", int'(frame_cnt), 0);

    // Good frame
    v0 = n_valid_seen;
    step(1'b0, 1'b1);
    pin("good_first_valid", int'(vif.valid_o), 1);
    pin("good_first_h", int'(vif.h_cnt_o), 0);
    pin("good_first_v", int'(vif.v_cnt_o), 0);
    repeat (W - 1) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    repeat (H - 1) do_line(W);
    eof("good", 1, 0);
    pin("good_valid_cnt", n_valid_seen - v0, W * H);
    pin("good_last_h", int'(vif.h_cnt_o), W - 1);
    pin("good_last_v", int'(vif.v_cnt_o), H - 1);
    pin("good_lerr", int'(line_err), 0);

    // Frame with one short line
    do_line(W); do_line(W);
    pin("short_pre_lerr", int'(line_err), 0);
    do_line(W - 1);
    pin("short_lerr", int'(line_err), 1);
    pin("short_ferr_pre_eof", int'(frame_err), 0);
    step(1'b0, 1'b1);
    pin("short_next_h", int'(vif.h_cnt_o), 0);
    pin("short_next_v", int'(vif.v_cnt_o), 3);
    repeat (W - 1) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    repeat (H - 4) do_line(W);
    eof("short", 2, 1);
    step(1'b0, 1'b0, 1'b1);
    pin("clr1_lerr", int'(line_err), 0);
    pin("clr1_ferr", int'(frame_err), 0);

    // Frame with one over-long line
    repeat (W) step(1'b0, 1'b1);
    pin("wide_last_valid", int'(vif.valid_o), 1);
    pin("wide_last_h", int'(vif.h_cnt_o), W - 1);
    step(1'b0, 1'b1);
    pin("wide_extra_valid", int'(vif.valid_o), 0);
    pin("wide_extra_h_hold", int'(vif.h_cnt_o), W - 1);
    pin("wide_lerr", int'(line_err), 1);
    repeat (3) step(1'b0, 1'b0);
    repeat (H - 1) do_line(W);
    eof("wide", 3, 1);
    step(1'b0, 1'b0, 1'b1);

    // Frame with one extra line
    repeat (H) do_line(W);
    v0 = n_valid_seen;
    do_line(W);
    pin("tall_extra_valid_cnt", n_valid_seen - v0, 0);
    pin("tall_lerr", int'(line_err), 1);
    eof("tall", 4, 1);
    step(1'b0, 1'b0, 1'b1);
    pin("clr_alone_lerr", int'(line_err), 0);
    pin("clr_alone_ferr", int'(frame_err), 0);
    repeat (3) step(1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    pin("clr_vs_line_set", int'(line_err), 1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    pin("clr_vs_frame_set", int'(frame_err), 1);
    pin("clr_vs_fcnt", int'(frame_cnt), 5);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);

    // Reset in the middle of a line
    repeat (5) do_line(W);
    repeat (8) step(1'b0, 1'b1);
    pin("midrst_pre_valid", int'(vif.valid_o), 1);
    rst_n = 1'b0;
    model_clear();
    apply_exp();
    #1;
    pin("midrst_valid", int'(vif.valid_o), 0);
    pin("midrst_h", int'(vif.h_cnt_o), 0);
    pin("midrst_v", int'(vif.v_cnt_o), 0);
    pin("midrst_r", int'(vif.r_o), 0);
    pin("midrst_fcnt", int'(frame_cnt), 0);
    pin("midrst_lerr", int'(line_err), 0);
    pin("midrst_ferr", int'(frame_err), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = n_valid_seen;
    repeat (8) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    pin("postrst_valid_cnt", n_valid_seen - v0, 0);
    s0 = n_vsync_seen;
    lock_pulse();
    pin("postrst_no_vsync", n_vsync_seen - s0, 0);
    pin("postrst_fcnt", int'(frame_cnt), 0);
    v0 = n_valid_seen;
    do_line(W);
    pin("postrst_line_valid_cnt", n_valid_seen - v0, W);
    pin("postrst_line_v", int'(vif.v_cnt_o), 0);
    repeat (2) step(1'b0, 1'b0);

    done = 1'b1;
  end

endmodule

// File: doc/video_coord_gen.md
Name: video_coord_gen

Overview:
- Upstream stage of the pixel-correction pipeline. Converts a raw source stream (vs/de/RGB) into the coordinate-tagged stream the correction stages consume: valid_o, h_cnt_o/v_cnt_o, a 1-cycle EOF pulse on vsync_o, and RGB.
- Locks to frame boundaries and suppresses out-of-range pixels, so downstream coordinates never exceed IMG_WIDTH-1 / IMG_HEIGHT-1.
- Flags malformed lines and frames.

Parameters:
- IMG_WIDTH, 1280, active pixels per line
- IMG_HEIGHT, 720, active lines per frame
- DATA_WIDTH, 8, bits per colour channel
- CNT_W, 11, coordinate counter width
- VS_POL, 1, vs_i active level (1 = active-high, 0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset
- vs_i  in  1  source vertical sync, level, synchronous to clk
- de_i  in  1  source data enable
- r_i, g_i, b_i  in  DATA_WIDTH each  source pixel
- clr_err_i  in  1  1-cycle pulse, clears sticky error flags
- valid_o  out  1  pixel valid
- vsync_o  out  1  EOF pulse, 1 cycle
- r_o, g_o, b_o  out  DATA_WIDTH each  pixel out
- h_cnt_o  out  CNT_W  column of current pixel
- v_cnt_o  out  CNT_W  row of current pixel
- line_err_o  out  1  sticky: some line width != IMG_WIDTH
- frame_err_o  out  1  sticky: some frame malformed
- frame_cnt_o  out  16  completed-frame count, wraps at 65535 -> 0

Behaviour:
- Reset: asynchronous, active-low, on rst_n; clock is clk. Every output resets to 0. State resets to SYNC_WAIT. Internal counters and edge registers clear.
- Derived signals:
  - vs_act = (vs_i == VS_POL).
  - de_eff = de_i & ~vs_act. de is ignored while vsync is active.
  - vs_edge = vs_act & ~vs_act_d.
  - line_end = de_eff_d & ~de_eff.
- All outputs are registered. Pixel latency is 1 clk: input cycle T appears on the outputs at T+1.
- State SYNC_WAIT:
  - valid_o = 0 and counters are held at 0.
  - On vs_edge: go to FRAME. No vsync_o pulse and no frame_cnt increment, since there is no complete frame yet.
- State FRAME, per pixel (de_eff = 1):
  - If hcnt < IMG_WIDTH and vcnt < IMG_HEIGHT: valid_o = 1, h_cnt_o = hcnt, v_cnt_o = vcnt, RGB passed through; hcnt++.
  - Else: pixel is suppressed (valid_o = 0) and line_err is set. hcnt saturates at IMG_WIDTH.
- State FRAME, on line_end:
  - If the pixel count of the line != IMG_WIDTH: set line_err and mark the current frame bad.
  - vcnt++ (saturates at IMG_HEIGHT+1); hcnt = 0.
- State FRAME, on vs_edge:
  - vsync_o = 1 for exactly 1 cycle at T+1.
  - frame_cnt_o++.
  - If vcnt != IMG_HEIGHT or the frame is marked bad: set frame_err.
  - Clear vcnt, hcnt and the frame-bad mark. Remain in FRAME.
- When line_end and vs_edge occur in the same cycle, line_end is applied first, so the EOF check counts that line.
- Lines outside the frame: lines with vcnt >= IMG_HEIGHT are fully suppressed; the frame is flagged at EOF.
- Error flags: line_err_o and frame_err_o are sticky and are cleared only by clr_err_i. Set has priority over clear in the same cycle.
- h_cnt_o, v_cnt_o and RGB hold their last values while valid_o = 0.
- Reset mid-frame returns to SYNC_WAIT. The partial frame is discarded, with no EOF pulse and no error.

Decomposition:
- Shared package video_pkg holds:
  - IMG_WIDTH/IMG_HEIGHT defaults (1280/720) and CNT_W.
  - The state encoding (SYNC_WAIT, FRAME).
  - A DATA_WIDTH default, shared with the correction stages.
- One sub-module, video_sync_edge: registers vs_act and de_eff and produces vs_edge and line_end. It is reused by later timing stages.
- Counters, FSM and error logic stay in the top module.

Test Plan:
- Reset, 50 de pixels before any vs edge -> valid_o stays 0. First vs edge -> no vsync_o pulse, frame_cnt_o = 0.
- Lock, then a full 1280x720 frame, then vs edge:
  - exactly 921600 valid_o cycles;
  - first pixel h=0, v=0; last pixel h=1279, v=719;
  - vsync_o high one cycle, 1 clk after edge; frame_cnt_o = 1; no errors.
- One line of 1279 pixels in an otherwise good frame -> line_err_o = 1 after that line_end; frame_err_o = 1 after EOF; the next line starts at h=0 with v incremented.
- One line of 1281 pixels -> 1281st pixel gives valid_o = 0 and h_cnt_o holds 1279; line_err_o = 1.
- 721 lines -> line 721 fully suppressed; frame_err_o = 1 at EOF. Then:
  - clr_err_i alone -> both flags 0;
  - clr_err_i in the same cycle as a new error -> flag stays 1.
- rst_n low mid-line (row 300) -> all outputs 0 immediately. Following pixels give no valid_o until the next vs edge, which gives no EOF pulse.
